// File: rtl/idct_1d_seq.sv
// Sequential 8-point 1-D inverse DCT built around one shared MAC; sign-magnitude Q11.4 in and out.
// Defining IDCT_SAT_FLAG_EN adds the sat_flag output (a result of the current set was clipped).
module idct_1d_seq #(
    parameter int DW    = 16,
    parameter int FRAC  = 4,
    parameter int CW    = 16,
    parameter int CFRAC = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] Y0,
    input  logic [DW-1:0] Y1,
    input  logic [DW-1:0] Y2,
    input  logic [DW-1:0] Y3,
    input  logic [DW-1:0] Y4,
    input  logic [DW-1:0] Y5,
    input  logic [DW-1:0] Y6,
    input  logic [DW-1:0] Y7,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y0,
    output logic [DW-1:0] y1,
    output logic [DW-1:0] y2,
    output logic [DW-1:0] y3,
    output logic [DW-1:0] y4,
    output logic [DW-1:0] y5,
    output logic [DW-1:0] y6,
    output logic [DW-1:0] y7
`ifdef IDCT_SAT_FLAG_EN
    ,
    output logic          sat_flag
`endif
);

    // state | meaning
    // IDLE  | ready for a coefficient set
    // CALC  | 64 MAC cycles, k inner loop, n outer loop
    // DONE  | results held until the consumer takes them
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int XW    = DW + 1;
    localparam int PW    = XW + CW;
    localparam int AW    = PW + 2;
    // Inputs and outputs share FRAC, so only the ROM scale has to be shifted out.
    localparam int SHIFT = (FRAC + CFRAC) - FRAC;
    localparam logic signed [AW-1:0] MAXV = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] RND  = AW'(2 ** (SHIFT - 1));

    function automatic logic signed [XW-1:0] sm_to_tc(input logic [DW-1:0] v);
        logic signed [XW-1:0] m;
        m = {2'b00, v[DW-2:0]};
        return v[DW-1] ? -m : m;
    endfunction

    // Folds the phase (2n+1)k mod 32 onto the first quadrant of cos(p*pi/16).
    function automatic logic signed [CW-1:0] rom(input logic [2:0] n, input logic [2:0] k);
        logic [4:0]           p;
        logic [3:0]           j;
        logic                 neg;
        logic signed [CW-1:0] v;
        p   = {1'b0, n, 1'b1} * {2'b00, k};
        neg = 1'b0;
        if (p > 5'd16) p = 5'd0 - p;
        if (p > 5'd8) begin
            neg = 1'b1;
            j   = 4'(5'd16 - p);
        end else begin
            j = p[3:0];
        end
        case (j)
            4'd0:    v = CW'(8192);
            4'd1:    v = CW'(8035);
            4'd2:    v = CW'(7568);
            4'd3:    v = CW'(6811);
            4'd4:    v = CW'(5793);
            4'd5:    v = CW'(4551);
            4'd6:    v = CW'(3135);
            4'd7:    v = CW'(1598);
            default: v = '0;
        endcase
        if (k == 3'd0) v = CW'(5793);
        return neg ? -v : v;
    endfunction

    logic [1:0]           state;
    logic [2:0]           n;
    logic [2:0]           k;
    logic                 out_valid_q;
    logic [DW-1:0]        coef_in [8];
    logic signed [XW-1:0] x_reg [8];
    logic [DW-1:0]        y_reg [8];
    logic signed [CW-1:0] coef;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] acc_rnd;
    logic signed [AW-1:0] r_full;
    logic                 ovf;
    logic [DW-2:0]        mag;
    logic [DW-1:0]        y_new;
`ifdef IDCT_SAT_FLAG_EN
    logic                 sat_q;
`endif

    assign coef_in[0] = Y0;
    assign coef_in[1] = Y1;
    assign coef_in[2] = Y2;
    assign coef_in[3] = Y3;
    assign coef_in[4] = Y4;
    assign coef_in[5] = Y5;
    assign coef_in[6] = Y6;
    assign coef_in[7] = Y7;

    assign coef    = rom(n, k);
    assign prod    = PW'(x_reg[k]) * PW'(coef);
    assign acc_sum = acc + {{(AW-PW){prod[PW-1]}}, prod};
    assign acc_rnd = acc_sum + RND;
    assign r_full  = acc_rnd >>> SHIFT;
    assign ovf     = (r_full > MAXV) || (r_full < -MAXV);
    // A zero result keeps sign 0, so 0x8000 is never produced.
    assign mag     = ovf ? '1 : (DW-1)'(r_full[AW-1] ? -r_full : r_full);
    assign y_new   = {r_full[AW-1], mag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            n           <= '0;
            k           <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
`ifdef IDCT_SAT_FLAG_EN
            sat_q       <= 1'b0;
`endif
            for (int i = 0; i < 8; i++) begin
                x_reg[i] <= '0;
                y_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 8; i++) x_reg[i] <= sm_to_tc(coef_in[i]);
                        acc   <= '0;
                        n     <= '0;
                        k     <= '0;
`ifdef IDCT_SAT_FLAG_EN
                        sat_q <= 1'b0;
`endif
                        state <= CALC;
                    end
                end
                CALC: begin
                    k <= k + 3'd1;
                    if (k == 3'd7) begin
                        y_reg[n] <= y_new;
                        acc      <= '0;
                        n        <= n + 3'd1;
`ifdef IDCT_SAT_FLAG_EN
                        sat_q    <= sat_q | ovf;
`endif
                        if (n == 3'd7) state <= DONE;
                    end else begin
                        acc <= acc_sum;
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign y0 = y_reg[0];
    assign y1 = y_reg[1];
    assign y2 = y_reg[2];
    assign y3 = y_reg[3];
    assign y4 = y_reg[4];
    assign y5 = y_reg[5];
    assign y6 = y_reg[6];
    assign y7 = y_reg[7];
`ifdef IDCT_SAT_FLAG_EN
    assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_idct_1d_seq.sv
// Bench for idct_1d_seq: vector table plus scoreboard, with hold, reset-abort and round-trip sequences.
module tb_idct_1d_seq;
    typedef logic [7:0][15:0] set_t;
    typedef struct packed { set_t y; logic sat; logic tol; } exp_t;
    typedef struct packed { set_t yin; exp_t exp; } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    set_t yin;
    logic in_ready;
    logic out_valid;
    logic [15:0] y0, y1, y2, y3, y4, y5, y6, y7;
    set_t yout;
`ifdef IDCT_SAT_FLAG_EN
    logic sat_flag;
`endif

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e_m;

    idct_1d_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Y0(yin[0]), .Y1(yin[1]), .Y2(yin[2]), .Y3(yin[3]),
        .Y4(yin[4]), .Y5(yin[5]), .Y6(yin[6]), .Y7(yin[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7)
`ifdef IDCT_SAT_FLAG_EN
        , .sat_flag(sat_flag)
`endif
    );

    assign yout = {y7, y6, y5, y4, y3, y2, y1, y0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int sm2i(logic [15:0] v);
        return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
    endfunction

    function automatic logic [15:0] i2sm(int v);
        logic [15:0] r;
        if (v < 0) r = {1'b1, 15'(-v)};
        else       r = {1'b0, 15'(v)};
        return r;
    endfunction

    function automatic real cfun(int nn, int kk);
        real c;
        c = 0.5 * $cos(real'((2 * nn + 1) * kk) * 3.14159265358979 / 16.0);
        if (kk == 0) c = c / $sqrt(2.0);
        return c;
    endfunction

    function automatic exp_t model(set_t s);
        exp_t e;
        e.sat = 1'b0;
        e.tol = 1'b0;
        e.y   = '0;
        for (int nn = 0; nn < 8; nn++) begin
            longint acc;
            longint r;
            acc = 0;
            for (int kk = 0; kk < 8; kk++) begin
                longint c;
                longint x;
                c = longint'(cfun(nn, kk) * 16384.0);
                x = longint'(s[kk][14:0]);
                if (s[kk][15]) x = -x;
                acc += x * c;
            end
            r = (acc + 8192) >>> 14;
            if (r > 32767) begin
                e.y[nn] = 16'h7FFF;
                e.sat   = 1'b1;
            end else if (r < -32767) begin
                e.y[nn] = 16'hFFFF;
                e.sat   = 1'b1;
            end else begin
                e.y[nn] = i2sm(int'(r));
            end
        end
        return e;
    endfunction

    task automatic send(input set_t s, input exp_t e, output int t_acc);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            t_acc = -1;
            return;
        end
        yin      = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t_acc    = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_out(input int t_acc);
        int w;
        w = 0;
        if (t_acc < 0) return;
        @(negedge clk);
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
            if (sb.size() > 0) void'(sb.pop_back());
        end else begin
            chk("latency", cyc - t_acc, 65);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready && out_valid) begin
                n_vec++;
                n_bad++;
                $display("FAIL ready_valid_overlap: got 1 expected 0");
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got set expected none");
                end else begin
                    e_m = sb.pop_front();
                    for (int i = 0; i < 8; i++) begin
                        if (e_m.tol) begin
                            int d;
                            d = sm2i(yout[i]) - sm2i(e_m.y[i]);
                            n_vec++;
                            if (d > 1 || d < -1) begin
                                n_bad++;
                                $display("FAIL roundtrip_y%0d: got %h expected %h +/-1", i, yout[i], e_m.y[i]);
                            end
                        end else begin
                            chk($sformatf("y%0d", i), yout[i], e_m.y[i]);
                        end
                    end
`ifdef IDCT_SAT_FLAG_EN
                    if (!e_m.tol) chk("sat_flag", sat_flag, e_m.sat);
`endif
                end
            end
        end
    end

    initial begin
        vec_t tbl[9];
        exp_t e;
        set_t s;
        int   t;
        int   xs[8];
        real  yk;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        yin       = '0;

        tbl[0].yin = '0; tbl[0].yin[0] = 16'h02D4;
        tbl[0].exp.y = {8{16'h0100}}; tbl[0].exp.sat = 1'b0; tbl[0].exp.tol = 1'b0;
        tbl[1].yin = '0; tbl[1].yin[0] = 16'h8080;
        tbl[1].exp.y = {8{16'h802D}}; tbl[1].exp.sat = 1'b0; tbl[1].exp.tol = 1'b0;
        tbl[2].yin = '0; tbl[2].yin[1] = 16'h0010;
        tbl[2].exp = model(tbl[2].yin);
        tbl[2].exp.y[0] = 16'h0008; tbl[2].exp.y[7] = 16'h8008;
        tbl[2].exp.y[3] = 16'h0002; tbl[2].exp.y[4] = 16'h8002;
        tbl[3].yin = {8{16'h7FFF}};
        tbl[3].exp = model(tbl[3].yin);
        tbl[3].exp.y[0] = 16'h7FFF; tbl[3].exp.sat = 1'b1;
        tbl[4].yin = {8{16'h8000}};
        tbl[4].exp.y = '0; tbl[4].exp.sat = 1'b0; tbl[4].exp.tol = 1'b0;
        tbl[5].yin = {8{16'hFFFF}};
        tbl[5].exp = model(tbl[5].yin);
        tbl[5].exp.y[0] = 16'hFFFF; tbl[5].exp.sat = 1'b1;
        for (int v = 6; v < 9; v++) begin
            for (int i = 0; i < 8; i++)
                tbl[v].yin[i] = {1'($urandom), 15'($urandom_range(0, 6000))};
            tbl[v].exp = model(tbl[v].yin);
        end

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_y%0d", i), yout[i], 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);

        for (int v = 0; v < 9; v++) begin
            send(tbl[v].yin, tbl[v].exp, t);
            wait_out(t);
        end

        // Consumer stalls for 10 cycles while a new set is offered.
        for (int i = 0; i < 8; i++) s[i] = {1'($urandom), 15'($urandom_range(0, 3000))};
        e = model(s);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(s, e, t);
        wait_out(t);
        yin      = {8{16'h1234}};
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            if (c == 0 || c == 9)
                for (int i = 0; i < 8; i++) chk($sformatf("hold_y%0d", i), yout[i], e.y[i]);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);

        // Reset in the middle of CALC discards the partial set.
        for (int i = 0; i < 8; i++) s[i] = {1'($urandom), 15'($urandom_range(0, 3000))};
        send(s, model(s), t);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("abort_y%0d", i), yout[i], 16'h0000);
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) s[i] = {1'($urandom), 15'($urandom_range(0, 3000))};
        send(s, model(s), t);
        wait_out(t);

        // Forward DCT of a known row, quantised to Q4, must come back within one LSB.
        xs = '{16, 20, 15, 30, 12, 13, 12, 13};
        for (int kk = 0; kk < 8; kk++) begin
            yk = 0.0;
            for (int nn = 0; nn < 8; nn++) yk += cfun(nn, kk) * real'(xs[nn]);
            s[kk] = i2sm(int'(yk * 16.0));
        end
        for (int nn = 0; nn < 8; nn++) e.y[nn] = i2sm(xs[nn] * 16);
        e.sat = 1'b0;
        e.tol = 1'b1;
        send(s, e, t);
        wait_out(t);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
